// File: rtl/stall_bubble_ctrl.sv
// PC / IF-ID / ID-EX register control for load-use stalls and branch flushes,
// with event counters and a sticky hazard-protocol monitor.
module stall_bubble_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcen,
  input  logic        ctrlsig,
  input  logic        flush,
  input  logic [31:0] pcnext,
  input  logic [31:0] instrin,
  input  logic [8:0]  ctrlin,
  output logic [31:0] pc,
  output logic [31:0] ifidinstr,
  output logic [31:0] ifidpc4,
  output logic [8:0]  idexctrl,
  output logic [15:0] stallcnt,
  output logic [15:0] flushcnt,
  output logic        protoerr
);

  typedef enum logic {RUN, STALL} state_t;

  state_t state, state_nxt;
  logic   hold;
  logic   perr_set;

  assign hold = !pcen && !flush;

  always_comb begin
    state_nxt = state;
    perr_set  = 1'b0;
    unique case (state)
      RUN: begin
        if (hold) state_nxt = STALL;
      end
      STALL: begin
        if (hold) perr_set  = 1'b1;
        else      state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    // a hold without a bubble re-executes the held instruction
    if (hold && !ctrlsig) perr_set = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      protoerr <= 1'b0;
    end else begin
      state <= state_nxt;
      if (perr_set) protoerr <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= '0;
      ifidinstr <= '0;
      ifidpc4   <= '0;
      idexctrl  <= '0;
    end else begin
      unique case (1'b1)
        flush: begin
          pc        <= pcnext;
          ifidinstr <= '0;
          ifidpc4   <= '0;
        end
        pcen: begin
          pc        <= pcnext;
          ifidinstr <= instrin;
          ifidpc4   <= pc + 32'd4;
        end
        default: begin
          pc        <= pc;
          ifidinstr <= ifidinstr;
          ifidpc4   <= ifidpc4;
        end
      endcase
      if (flush || ctrlsig) idexctrl <= '0;
      else                  idexctrl <= ctrlin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stallcnt <= '0;
      flushcnt <= '0;
    end else begin
      if (hold && stallcnt != 16'hFFFF)
        stallcnt <= stallcnt + 16'd1;
      if (flush && flushcnt != 16'hFFFF)
        flushcnt <= flushcnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_stall_bubble_ctrl.sv
// Bench for stall_bubble_ctrl: per-cycle model comparison
// plus literal checks on directed scenarios.
module tb_stall_bubble_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pcen = 1'b0;
  logic        ctrlsig = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pcnext = '0;
  logic [31:0] instrin = '0;
  logic [8:0]  ctrlin = '0;
  logic [31:0] pc, ifidinstr, ifidpc4;
  logic [8:0]  idexctrl;
  logic [15:0] stallcnt, flushcnt;
  logic        protoerr;

  int cmp_cnt = 0;
  int err_cnt = 0;

  stall_bubble_ctrl dut (
    .clk(clk), .rst(rst), .pcen(pcen), .ctrlsig(ctrlsig),
    .flush(flush), .pcnext(pcnext), .instrin(instrin),
    .ctrlin(ctrlin), .pc(pc), .ifidinstr(ifidinstr),
    .ifidpc4(ifidpc4), .idexctrl(idexctrl),
    .stallcnt(stallcnt), .flushcnt(flushcnt),
    .protoerr(protoerr)
  );

  always #5 clk = ~clk;

  // model state
  bit          m_valid = 1'b0;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic [8:0]  m_ctrl;
  int          m_stall, m_flush;
  bit          m_err, m_prev_hold;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_ctrl = 0;
      m_stall = 0; m_flush = 0; m_err = 0; m_prev_hold = 0;
    end else if (m_valid) begin
      bit hold;
      hold = !pcen && !flush;
      if (flush) begin
        m_pc4 = 0; m_instr = 0; m_pc = pcnext;
      end else if (pcen) begin
        m_pc4 = m_pc + 32'd4; m_instr = instrin; m_pc = pcnext;
      end
      m_ctrl = (flush || ctrlsig) ? 9'd0 : ctrlin;
      if (hold && m_stall < 65535) m_stall++;
      if (flush && m_flush < 65535) m_flush++;
      if (hold && (!ctrlsig || m_prev_hold)) m_err = 1;
      m_prev_hold = hold;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m.pc", pc, m_pc);
      chk("m.ifidinstr", ifidinstr, m_instr);
      chk("m.ifidpc4", ifidpc4, m_pc4);
      chk("m.idexctrl", {23'd0, idexctrl}, {23'd0, m_ctrl});
      chk("m.stallcnt", {16'd0, stallcnt}, m_stall);
      chk("m.flushcnt", {16'd0, flushcnt}, m_flush);
      chk("m.protoerr", {31'd0, protoerr}, {31'd0, m_err});
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drv(input logic p, input logic c, input logic f,
                     input logic [31:0] nx, input logic [31:0] in,
                     input logic [8:0] ci);
    pcen = p; ctrlsig = c; flush = f;
    pcnext = nx; instrin = in; ctrlin = ci;
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1; pcen = 1'b0; ctrlsig = 1'b1; flush = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst.pc", pc, 0);
    chk("rst.instr", ifidinstr, 0);
    chk("rst.prot", {31'd0, protoerr}, 0);

    drv(1, 0, 0, 32'h4, 32'h8C220000, 9'h1AB);
    chk("run.pc", pc, 32'h4);
    chk("run.instr", ifidinstr, 32'h8C220000);
    chk("run.pc4", ifidpc4, 32'h4);
    chk("run.ctrl", {23'd0, idexctrl}, 32'h1AB);

    drv(1, 0, 0, 32'h8, 32'h00000013, 9'h0F0);
    chk("run2.pc4", ifidpc4, 32'h8);

    drv(0, 1, 0, 32'hC, 32'hDEADBEEF, 9'h1FF);
    chk("stall.pc", pc, 32'h8);
    chk("stall.instr", ifidinstr, 32'h13);
    chk("stall.pc4", ifidpc4, 32'h8);
    chk("stall.ctrl", {23'd0, idexctrl}, 0);
    chk("stall.cnt", {16'd0, stallcnt}, 1);
    chk("stall.prot", {31'd0, protoerr}, 0);

    drv(0, 1, 1, 32'h40, 32'hDEADBEEF, 9'h1FF);
    chk("flush.pc", pc, 32'h40);
    chk("flush.instr", ifidinstr, 0);
    chk("flush.ctrl", {23'd0, idexctrl}, 0);
    chk("flush.fcnt", {16'd0, flushcnt}, 1);
    chk("flush.scnt", {16'd0, stallcnt}, 1);

    drv(1, 0, 0, 32'h44, 32'hAAAA5555, 9'h155);
    chk("post.pc4", ifidpc4, 32'h44);
    drv(1, 1, 0, 32'h48, 32'h11111111, 9'h1FF);
    chk("bub.ctrl", {23'd0, idexctrl}, 0);
    chk("bub.pc", pc, 32'h48);

    drv(0, 1, 0, 32'h4C, 32'h0, 9'h0);
    chk("pe1.prot", {31'd0, protoerr}, 0);
    drv(0, 1, 0, 32'h4C, 32'h0, 9'h0);
    chk("pe2.prot", {31'd0, protoerr}, 1);
    chk("pe2.cnt", {16'd0, stallcnt}, 3);
    drv(1, 0, 0, 32'h50, 32'h0, 9'h3);
    drv(1, 0, 0, 32'h54, 32'h0, 9'h3);
    chk("pe.sticky", {31'd0, protoerr}, 1);

    do_reset();
    chk("rst2.prot", {31'd0, protoerr}, 0);
    drv(0, 0, 0, 32'h0, 32'h0, 9'h7);
    chk("nobub.prot", {31'd0, protoerr}, 1);

    do_reset();
    drv(1, 0, 0, 32'hFFFFFFFC, 32'h1, 9'h1);
    chk("wrap.pc", pc, 32'hFFFFFFFC);
    drv(1, 0, 0, 32'h0, 32'h2, 9'h2);
    chk("wrap.pc4", ifidpc4, 32'h0);

    // a reset pulse between edges must not disturb anything
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    cyc();
    chk("glitch.pc", pc, 32'h0);
    chk("glitch.instr", ifidinstr, 32'h2);

    pcen = 0; ctrlsig = 1; flush = 0;
    for (int i = 0; i < 65540; i++) cyc();
    chk("sat.cnt", {16'd0, stallcnt}, 32'hFFFF);

    drv(0, 1, 1, 32'h80, 32'h0, 9'h0);
    drv(0, 1, 0, 32'h84, 32'h0, 9'h0);
    rst = 1'b1;
    drv(0, 1, 0, 32'h88, 32'h9, 9'h9);
    rst = 1'b0;
    chk("mid.pc", pc, 0);
    chk("mid.pc4", ifidpc4, 0);
    chk("mid.scnt", {16'd0, stallcnt}, 0);
    chk("mid.fcnt", {16'd0, flushcnt}, 0);
    chk("mid.prot", {31'd0, protoerr}, 0);
    drv(1, 0, 0, 32'h100, 32'h77, 9'h5);
    chk("after.pc", pc, 32'h100);
    chk("after.pc4", ifidpc4, 32'h4);
    drv(0, 1, 0, 32'h104, 32'h0, 9'h0);
    chk("after.prot", {31'd0, protoerr}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_cnt, err_cnt);
    $finish;
  end

endmodule
